// File: rtl/sram_ctrl.sv
// sram_ctrl: splits byte/half/word bus requests into registered little-endian byte cycles on an async SRAM.
// Define SRAM_CTRL_WORD_EN to support half/word sizes; otherwise only byte requests are legal.
`ifndef IOR_DIR_OUT
`define IOR_DIR_OUT 1'b1
`endif
`ifndef IOR_DIR_IN
`define IOR_DIR_IN 1'b0
`endif
module sram_ctrl #(
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [18:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_vld,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        sram_ce_bar,
  output logic        sram_oe_bar,
  output logic        sram_we_bar,
  output logic        sram_data_dir,
  output logic [7:0]  sram_data_out,
  input  logic [7:0]  sram_data_in,
  output logic [18:0] sram_addr
);
  typedef enum logic [2:0] {IDLE, RD, WR_SU, WR_PL, WR_HD, RESP} state_t;
  localparam logic [2:0] RDW = 3'(RD_WAIT);
  localparam logic [2:0] WRW = 3'(WR_WAIT);
  state_t state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic [18:0] base_q, base_d, addr_q, addr_d;
  logic [7:0] dout_q, dout_d;
  logic ce_q, ce_d, oe_q, oe_d, we_q, we_d, dir_q, dir_d;
  logic rdy_q, rdy_d, vld_q, vld_d, err_q, err_d;
  logic acc_err;
`ifdef SRAM_CTRL_WORD_EN
  logic [1:0] k_q, k_d, last_q, last_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  assign acc_err = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && req_addr[1:0] != 2'd0);
  assign resp_rdata = rdata_q;
`else
  logic [7:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic unused_wdata;
  assign unused_wdata = ^req_wdata[31:8];
  assign acc_err = req_size != 2'd0;
  assign resp_rdata = {24'd0, rdata_q};
`endif
  assign req_rdy       = rdy_q;
  assign resp_vld      = vld_q;
  assign resp_err      = err_q;
  assign sram_ce_bar   = ce_q;
  assign sram_oe_bar   = oe_q;
  assign sram_we_bar   = we_q;
  assign sram_data_dir = dir_q;
  assign sram_data_out = dout_q;
  assign sram_addr     = addr_q;
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef SRAM_CTRL_WORD_EN
    k_d     = k_q;
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: if (req_vld) begin
        base_d  = req_addr;
        rdata_d = '0;
        err_d   = acc_err;
        wait_d  = '0;
`ifdef SRAM_CTRL_WORD_EN
        k_d     = '0;
        last_d  = {req_size[1], |req_size};
        wdata_d = req_wdata;
`else
        wdata_d = req_wdata[7:0];
`endif
        state_d = acc_err ? RESP : req_we ? WR_SU : RD;
      end
      RD: if (wait_q == RDW) begin
        wait_d  = '0;
`ifdef SRAM_CTRL_WORD_EN
        rdata_d[{k_q, 3'b000} +: 8] = sram_data_in;
        k_d     = k_q + 2'd1;
        state_d = (k_q == last_q) ? RESP : RD;
`else
        rdata_d = sram_data_in;
        state_d = RESP;
`endif
      end else wait_d = wait_q + 3'd1;
      WR_SU: begin
        wait_d  = '0;
        state_d = WR_PL;
      end
      WR_PL: if (wait_q == WRW) state_d = WR_HD;
             else wait_d = wait_q + 3'd1;
      WR_HD: begin
`ifdef SRAM_CTRL_WORD_EN
        k_d     = k_q + 2'd1;
        state_d = (k_q == last_q) ? RESP : WR_SU;
`else
        state_d = RESP;
`endif
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are derived from the next state so every pin comes straight off a flop.
    ce_d  = !(state_d inside {RD, WR_SU, WR_PL, WR_HD});
    oe_d  = state_d != RD;
    we_d  = state_d != WR_PL;
    dir_d = (state_d inside {WR_SU, WR_PL, WR_HD}) ? `IOR_DIR_OUT : `IOR_DIR_IN;
    rdy_d = state_d == IDLE;
    vld_d = state_d == RESP;
`ifdef SRAM_CTRL_WORD_EN
    addr_d = (state_d == RD || state_d == WR_SU) ? base_d + {17'd0, k_d} : addr_q;
    dout_d = (state_d == WR_SU) ? wdata_d[{k_d, 3'b000} +: 8] : dout_q;
`else
    addr_d = (state_d == RD || state_d == WR_SU) ? base_d : addr_q;
    dout_d = (state_d == WR_SU) ? wdata_d : dout_q;
`endif
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      wait_q  <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      dir_q   <= `IOR_DIR_IN;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
`ifdef SRAM_CTRL_WORD_EN
      k_q     <= '0;
      last_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      dir_q   <= dir_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
`ifdef SRAM_CTRL_WORD_EN
      k_q     <= k_d;
      last_q  <= last_d;
`endif
    end
  end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed bench for sram_ctrl with a byte-wide SRAM model and a strobe/bus monitor.
`ifndef IOR_DIR_OUT
`define IOR_DIR_OUT 1'b1
`endif
`ifndef IOR_DIR_IN
`define IOR_DIR_IN 1'b0
`endif
module tb_sram_ctrl;
`ifdef SRAM_CTRL_WORD_EN
  localparam bit WORD = 1'b1;
`else
  localparam bit WORD = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b1;
  logic req_vld = 1'b0, req_we = 1'b0, req_rdy, resp_vld, resp_err;
  logic [1:0] req_size = 2'd0;
  logic [18:0] req_addr = '0, sram_addr;
  logic [31:0] req_wdata = '0, resp_rdata;
  logic sram_ce_bar, sram_oe_bar, sram_we_bar, sram_data_dir;
  logic [7:0] sram_data_out, sram_data_in;
  logic [7:0] mem [0:(1<<19)-1];
  int checks = 0, errors = 0;
  int ce_lo = 0, we_lo = 0, rdy_lo = 0, viol = 0;
  logic pw = 1'b1;
  logic [18:0] pa = '0;
  logic [7:0] pd = '0;
  int lat;
  logic [31:0] rd;
  logic err, saw;

  sram_ctrl dut (
    .clk(clk), .rstn(rstn), .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_vld(resp_vld), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_ce_bar(sram_ce_bar), .sram_oe_bar(sram_oe_bar), .sram_we_bar(sram_we_bar),
    .sram_data_dir(sram_data_dir), .sram_data_out(sram_data_out),
    .sram_data_in(sram_data_in), .sram_addr(sram_addr)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < (1 << 19); i++) mem[i] = 8'h00;
  assign sram_data_in = (!sram_ce_bar && !sram_oe_bar) ? mem[sram_addr] : 8'h00;
  always @(posedge sram_we_bar) if (rstn && !sram_ce_bar) mem[sram_addr] = sram_data_out;

  // we_bar must never move together with addr/data; never drive while the SRAM drives.
  always @(posedge clk) begin
    #2;
    if (rstn && sram_we_bar !== pw && (sram_addr !== pa || sram_data_out !== pd)) viol++;
    if (!sram_oe_bar && sram_data_dir === `IOR_DIR_OUT) viol++;
    pw = sram_we_bar;
    pa = sram_addr;
    pd = sram_data_out;
    ce_lo += int'(!sram_ce_bar);
    we_lo += int'(!sram_we_bar);
    rdy_lo += int'(!req_rdy);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [1:0] size, input logic [18:0] a,
                      input logic [31:0] wd, output int l, output logic [31:0] r, output logic e);
    @(negedge clk);
    chk("req_rdy", {31'd0, req_rdy}, 32'd1);
    req_vld = 1'b1; req_we = we; req_size = size; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_vld = 1'b0;
    l = 0; r = 'x; e = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (resp_vld) begin
        l = c; r = resp_rdata; e = resp_err;
        break;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {27'd0, sram_ce_bar, sram_oe_bar, sram_we_bar, sram_data_dir, req_rdy},
        {27'd0, 1'b1, 1'b1, 1'b1, `IOR_DIR_IN, 1'b1});
    chk({tag, "_addr"}, {13'd0, sram_addr}, 32'd0);
    chk({tag, "_resp"}, {23'd0, sram_data_out, resp_vld}, 32'd0);
    chk({tag, "_rdata"}, {resp_rdata[31:1], resp_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    #1 rstn = 1'b1;
    ce_lo = 0; we_lo = 0; rdy_lo = 0;
    repeat (100) @(negedge clk);
    chk("idle_ce", ce_lo, 0);
    chk("idle_we", we_lo, 0);
    chk("idle_rdy", rdy_lo, 0);
    chk_reset_outputs("idle");

    we_lo = 0;
    xfer(1'b1, 2'd2, 19'h00100, 32'hA1B2C3D4, lat, rd, err);
    chk("wwr_lat", lat, WORD ? 17 : 1);
    chk("wwr_err", {31'd0, err}, {31'd0, !WORD});
    chk("wwr_welo", we_lo, WORD ? 8 : 0);
    chk("wwr_mem", {mem[19'h103], mem[19'h102], mem[19'h101], mem[19'h100]}, WORD ? 32'hA1B2C3D4 : 32'h0);

    xfer(1'b0, 2'd2, 19'h00100, 32'h0, lat, rd, err);
    chk("wrd_lat", lat, WORD ? 9 : 1);
    chk("wrd_data", rd, WORD ? 32'hA1B2C3D4 : 32'h0);
    chk("wrd_err", {31'd0, err}, {31'd0, !WORD});

    xfer(1'b0, 2'd1, 19'h00102, 32'h0, lat, rd, err);
    chk("hrd_lat", lat, WORD ? 5 : 1);
    chk("hrd_data", rd, WORD ? 32'h0000A1B2 : 32'h0);

    ce_lo = 0;
    xfer(1'b0, 2'd1, 19'h00101, 32'h0, lat, rd, err);
    chk("mis_lat", lat, 1);
    chk("mis_err", {31'd0, err}, 32'd1);
    chk("mis_ce", ce_lo, 0);
    xfer(1'b1, 2'd3, 19'h00100, 32'hFFFFFFFF, lat, rd, err);
    chk("sz3_lat", lat, 1);
    chk("sz3_err", {31'd0, err}, 32'd1);
    chk("sz3_ce", ce_lo, 0);
    chk("sz3_mem", {24'd0, mem[19'h100]}, WORD ? 32'hD4 : 32'h0);

    xfer(1'b1, 2'd0, 19'h00200, 32'hEEEEEE55, lat, rd, err);
    chk("bwr_lat", lat, 5);
    chk("bwr_err", {31'd0, err}, 32'd0);
    chk("bwr_mem", {24'd0, mem[19'h200]}, 32'h55);
    xfer(1'b0, 2'd0, 19'h00200, 32'h0, lat, rd, err);
    chk("brd_lat", lat, 3);
    chk("brd_data", rd, 32'h00000055);

    xfer(1'b1, 2'd2, 19'h7FFFC, 32'h11223344, lat, rd, err);
    chk("top_wlat", lat, WORD ? 17 : 1);
    chk("top_mem", {mem[19'h7FFFF], mem[19'h7FFFE], mem[19'h7FFFD], mem[19'h7FFFC]}, WORD ? 32'h11223344 : 32'h0);
    chk("top_nowrap", {mem[19'h3], mem[19'h2], mem[19'h1], mem[19'h0]}, 32'h0);
    xfer(1'b0, 2'd2, 19'h7FFFC, 32'h0, lat, rd, err);
    chk("top_rlat", lat, WORD ? 9 : 1);
    chk("top_rdata", rd, WORD ? 32'h11223344 : 32'h0);
    xfer(1'b1, 2'd0, 19'h7FFFF, 32'h00000099, lat, rd, err);
    chk("topb_wlat", lat, 5);
    xfer(1'b0, 2'd0, 19'h7FFFF, 32'h0, lat, rd, err);
    chk("topb_rdata", rd, 32'h00000099);
    chk("topb_nowrap", {24'd0, mem[19'h0]}, 32'h0);

    // Abort a write while we_bar is low: word byte 2 pulse, or the only byte's pulse.
    @(negedge clk);
    req_vld = 1'b1; req_we = 1'b1; req_size = WORD ? 2'd2 : 2'd0;
    req_addr = 19'h00300; req_wdata = 32'h5A5A5A5A;
    @(posedge clk);
    #1 req_vld = 1'b0;
    repeat (WORD ? 10 : 2) @(negedge clk);
    chk("abort_pl", {31'd0, sram_we_bar}, 32'd0);
    #1 rstn = 1'b0;
    #1 chk_reset_outputs("abort");
    saw = 1'b0;
    repeat (3) @(negedge clk) saw |= resp_vld;
    #1 rstn = 1'b1;
    repeat (5) @(negedge clk) saw |= resp_vld;
    chk("abort_novld", {31'd0, saw}, 32'd0);
    xfer(1'b0, 2'd0, 19'h00200, 32'h0, lat, rd, err);
    chk("post_lat", lat, 3);
    chk("post_data", rd, 32'h00000055);
    chk("post_err", {31'd0, err}, 32'd0);

    chk("protocol", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Sequencer for the external byte-wide asynchronous SRAM (19-bit address, 8-bit data) behind the I/O ring. Accepts byte/half/word requests from a single bus master, splits them into little-endian byte cycles, and drives the SRAM strobes, address, data and data-direction with registered, glitch-free timing. All SRAM-side outputs feed the I/O ring's sram_* inputs directly.

## Interface
Parameters:
- RD_WAIT, 1: extra cycles oe_bar is held low before read data is sampled (0..7).
- WR_WAIT, 1: extra cycles we_bar is held low per write pulse (0..7).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- req_vld  in  1  request valid
- req_rdy  out  1  request accepted when req_vld & req_rdy
- req_we  in  1  1 = write, 0 = read
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
- req_addr  in  19  byte address
- req_wdata  in  32  write data, lane k -> addr+k
- resp_vld  out  1  one-cycle completion pulse, no backpressure
- resp_rdata  out  32  read data, valid with resp_vld, unused lanes 0
- resp_err  out  1  error flag, valid with resp_vld
- sram_ce_bar, sram_oe_bar, sram_we_bar  out  1 each  SRAM strobes
- sram_data_dir  out  1  `IOR_DIR_OUT` while driving, else `IOR_DIR_IN`
- sram_data_out  out  8  write byte
- sram_data_in  in  8  read byte from I/O ring
- sram_addr  out  19  SRAM address

## Operation
- Every sram_* output and resp_* output is a flop output. Reset values: ce/oe/we_bar = 1, data_dir = `IOR_DIR_IN`, data_out = 0, addr = 0, req_rdy = 1, resp_vld = 0, resp_rdata = 0, resp_err = 0.
- States: IDLE, RD, WR_SU, WR_PL, WR_HD, RESP.
- IDLE: req_rdy = 1, strobes inactive, dir IN. On accept: latch we/size/addr/wdata, byte count n = 1<<size, index k = 0, clear rdata.
- Error check on accept: size 3, or addr not aligned to n -> RESP with resp_err = 1, no SRAM activity.
- RD (per byte): ce_bar = 0, oe_bar = 0, addr = base+k; held RD_WAIT+1 cycles; on last cycle sram_data_in captured into lane k. Then k++ -> RD, or RESP. ce/oe stay low across bytes of one access.
- WR_SU (1 cycle): ce_bar = 0, we_bar = 1, addr = base+k, data_out = lane k, dir OUT.
- WR_PL (WR_WAIT+1 cycles): we_bar = 0, addr/data stable.
- WR_HD (1 cycle): we_bar = 1, addr/data/dir unchanged. Then k++ -> WR_SU, or RESP.
- RESP (1 cycle): resp_vld = 1, ce/oe/we_bar = 1, dir IN; next IDLE. req_rdy = 0 in every non-IDLE state.
- Address arithmetic: base + k in 19 bits; alignment guarantees no wrap (word at 0x7FFFC covers 0x7FFFC..0x7FFFF).
- rstn low mid-access: all outputs return to reset values immediately; access lost, no response.

## Timing
- Accept in cycle 0; first SRAM cycle starts cycle 1.
- Read byte count n: resp_vld in cycle 1 + n*(RD_WAIT+1). Defaults: byte 3, word 9.
- Write byte count n: resp_vld in cycle 1 + n*(WR_WAIT+3). Defaults: byte 5, word 17.
- Error: resp_vld in cycle 1.
- Next request accepted earliest the cycle after resp_vld (back-to-back throughput: one access per latency+1).
- RESP cycle guarantees one idle bus cycle between any read and a following write (no drive contention).
- we_bar never toggles in the same cycle as addr or data_out.

## Configuration
- SRAM_CTRL_WORD_EN defined: half and word sizes supported as above.
- Not defined: only size 0 legal; size 1/2/3 -> resp_err = 1 in cycle 1, no SRAM activity; byte-count/lane logic removed, resp_rdata[31:8] tied 0.

## Test plan
- Reset then idle: all outputs at reset values, req_rdy = 1, no strobe activity for 100 cycles.
- Word write 0xA1B2C3D4 to 0x00100, defaults: four WR_SU/WR_PL/WR_HD groups at 0x100..0x103 with bytes D4,C3,B2,A1; we_bar low 2 cycles each; resp_vld cycle 17, resp_err 0.
- Word read from 0x00100 (SRAM model holding above): resp_rdata = 0xA1B2C3D4 in cycle 9; half read at 0x00102 -> 0x0000A1B2 in cycle 5.
- Misaligned half read at 0x00101 and size 3: resp_err = 1 in cycle 1, ce_bar never low.
- Top-of-memory word write/read at 0x7FFFC: addresses 0x7FFFC..0x7FFFF, data round-trips, no wrap to 0.
- rstn asserted in WR_PL of byte 2: ce/we_bar = 1, dir IN same cycle (asynchronous), no resp_vld; next request after release completes normally.
